tcp_conn_fsm_multi: RTL and testbench
=====================================

Name: tcp_conn_fsm_multi

Overview:
- Multi-connection successor of the single TCP connection controller: NUM_CONN independent TCP state machines sharing one time-multiplexed event port and one transmit-flag port.
- Replaces the external timeout strobe with internal per-connection timers, and adds SYN retransmission with a bounded retry count.
- Sits between the segment parser/application command path and the segment builder.

Parameters:
NUM_CONN, 4, number of connections (1..64)
CONN_W, $clog2(NUM_CONN) min 1, connection-id width (derived)
TIMEOUT_CYCLES, 16, handshake/LAST_ACK timer reload (>=2)
TW_CYCLES, 32, TIME_WAIT timer reload (>=2)
TMR_W, 16, timer width; reloads must fit
MAX_RETRY, 2, SYN retransmissions before SYN_SENT gives up

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
evt_valid  in  1  event present this cycle (always accepted)
evt_conn  in  CONN_W  target connection
evt_flags  in  4  {SYN,ACK,FIN,RST} received flags
evt_cmd  in  4  {a_opn,p_opn,cls,send_data} application commands
tx_valid  out  1  transmit request valid
tx_conn  out  CONN_W  connection issuing request
tx_flags  out  4  {SYN,ACK,FIN,RST} to send
err_o  out  1  one-cycle pulse: evt_conn >= NUM_CONN
state_o  out  4*NUM_CONN  packed per-connection state, conn 0 in LSBs

Behaviour:
- Reset (rst_n low, async): all connections CLOSED, timers 0/disarmed, retry counts 0, pending-timeout flags 0, tx_valid=0, tx_conn=0, tx_flags=0, err_o=0.
- State codes: CLOSED=0 LISTEN=1 SYN_SENT=2 SYN_RCVD=3 ESTABLISHED=4 FIN_WAIT_1=5 FIN_WAIT_2=6 CLOSE_WAIT=7 CLOSING=8 LAST_ACK=9 TIME_WAIT=10; codes 11-15 are illegal and force CLOSED on the next processed step.
- Processing: one step per cycle. The step is the external event if evt_valid; otherwise the lowest-index connection with a pending timeout (a "TO" step). The state update, tx_valid/tx_conn/tx_flags, and err_o all register at the next clk edge (latency 1). tx_valid=0 when no transition emits flags.
- Transitions (first matching row wins; absent inputs = stay, no tx):
  - CLOSED: a_opn->SYN_SENT tx SYN; p_opn->LISTEN.
  - LISTEN: cls->CLOSED; send_data->SYN_SENT tx SYN; SYN->SYN_RCVD tx SYN+ACK.
  - SYN_SENT: cls->CLOSED; TO with retry<MAX_RETRY->stay, tx SYN, retry++, timer reload; TO with retry==MAX_RETRY->CLOSED tx RST; SYN&ACK->ESTABLISHED tx ACK; SYN->SYN_RCVD tx SYN+ACK.
  - SYN_RCVD: cls->FIN_WAIT_1 tx FIN; TO->CLOSED tx RST; ACK->ESTABLISHED; RST->LISTEN.
  - ESTABLISHED: cls->FIN_WAIT_1 tx FIN; FIN->CLOSE_WAIT tx ACK; RST->LISTEN.
  - FIN_WAIT_1: FIN&ACK->TIME_WAIT tx ACK; FIN->CLOSING tx ACK; ACK->FIN_WAIT_2.
  - FIN_WAIT_2: FIN->TIME_WAIT tx ACK.
  - CLOSE_WAIT: cls->LAST_ACK tx FIN.
  - CLOSING: ACK->TIME_WAIT.
  - LAST_ACK: ACK or TO->CLOSED.
  - TIME_WAIT: TO->CLOSED.
- Timers:
  - On entry to SYN_SENT, SYN_RCVD or LAST_ACK, the timer loads TIMEOUT_CYCLES; on entry to TIME_WAIT it loads TW_CYCLES.
  - Entry to any other state disarms the timer and clears its pending flag.
  - Entry to SYN_SENT from CLOSED or LISTEN clears retry.
  - An armed timer decrements every cycle. On reaching 0 it disarms and sets pending.
  - Pending is cleared when its TO step is processed or when the connection leaves the state via an external event.
  - An external event to a connection in the same cycle its timer expires is processed first. Pending then remains set, and the TO step applies to the resulting state only if that state is timer-bearing; otherwise pending is discarded.
- Out-of-range evt_conn: no state change, tx_valid=0, err_o=1 for one cycle. Pending timeouts are not serviced that cycle.
- Continuous evt_valid starves TO steps. This is permitted; timeouts are serviced on the first idle cycle.

Test Plan:
- Active open: evt conn1 a_opn -> next cycle tx_valid=1 tx_conn=1 tx_flags=SYN, state_o[7:4]=2; evt conn1 SYN+ACK -> tx ACK, state 4.
- SYN retry exhaustion (MAX_RETRY=2, TIMEOUT=16, no events): conn0 a_opn -> SYN retransmitted at cycles ~17 and ~33, RST at ~49, state 0; retry=0 on next a_opn.
- Passive open and close: conn2 p_opn, SYN -> tx SYN+ACK; ACK -> state 4; FIN -> tx ACK, state 7; cls -> tx FIN, state 9; no ACK -> CLOSED after 16 cycles with tx_valid=0.
- Simultaneous close: conn3 ESTABLISHED cls -> tx FIN; FIN -> tx ACK, state 8; ACK -> state 10; CLOSED exactly TW_CYCLES later, other connections unaffected.
- Timeout vs event collision: conn0 and conn1 expire the same cycle while evt_valid targets conn0 with ACK in SYN_RCVD -> conn0 becomes ESTABLISHED and its pending is discarded; conn1 TO is processed on the next idle cycle.
- Boundaries: evt_conn=NUM_CONN -> err_o pulse, no tx; rst_n asserted mid-handshake -> all state_o=0 and tx_valid=0 immediately.

Source files
------------

// File: rtl/tcp_conn_fsm_multi_if.sv
// Event/transmit bus of the multi-connection TCP controller.
// The master drives events; the slave (controller) returns tx requests and state.
interface tcp_conn_fsm_multi_if #(
  parameter int NUM_CONN = 4,
  parameter int CONN_W   = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1
);
  logic                    evt_valid;
  logic [CONN_W-1:0]       evt_conn;
  logic [3:0]              evt_flags;
  logic [3:0]              evt_cmd;
  logic                    tx_valid;
  logic [CONN_W-1:0]       tx_conn;
  logic [3:0]              tx_flags;
  logic                    err_o;
  logic [4*NUM_CONN-1:0]   state_o;

  modport master (
    output evt_valid, evt_conn, evt_flags, evt_cmd,
    input  tx_valid, tx_conn, tx_flags, err_o, state_o
  );

  modport slave (
    input  evt_valid, evt_conn, evt_flags, evt_cmd,
    output tx_valid, tx_conn, tx_flags, err_o, state_o
  );
endinterface

// File: rtl/tcp_conn_fsm_multi.sv
// NUM_CONN TCP connection FSMs sharing one event port; one step per cycle
// (external event, else lowest-index pending timeout), with per-connection timers.
module tcp_conn_fsm_multi #(
  parameter int NUM_CONN       = 4,
  parameter int CONN_W         = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TW_CYCLES      = 32,
  parameter int TMR_W          = 16,
  parameter int MAX_RETRY      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tcp_conn_fsm_multi_if.slave  bus
);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_CLOSED = 4'd0, S_LISTEN = 4'd1, S_SYN_SENT = 4'd2, S_SYN_RCVD = 4'd3,
    S_ESTAB = 4'd4, S_FIN_WAIT_1 = 4'd5, S_FIN_WAIT_2 = 4'd6, S_CLOSE_WAIT = 4'd7,
    S_CLOSING = 4'd8, S_LAST_ACK = 4'd9, S_TIME_WAIT = 4'd10
  } state_e;

  localparam logic [3:0] F_SYN = 4'b1000;
  localparam logic [3:0] F_ACK = 4'b0100;
  localparam logic [3:0] F_FIN = 4'b0010;
  localparam logic [3:0] F_RST = 4'b0001;

  state_e              r_state [NUM_CONN];
  logic [TMR_W-1:0]    r_tmr   [NUM_CONN];
  logic [RTY_W-1:0]    r_retry [NUM_CONN];
  logic [NUM_CONN-1:0] r_armed, r_pend;
  logic                r_tx_valid;
  logic [CONN_W-1:0]   r_tx_conn;
  logic [3:0]          r_tx_flags;
  logic                r_err;

  state_e              w_nstate [NUM_CONN];
  logic [TMR_W-1:0]    w_ntmr   [NUM_CONN];
  logic [RTY_W-1:0]    w_nretry [NUM_CONN];
  logic [NUM_CONN-1:0] w_narmed, w_npend, w_exp, w_due;
  logic                w_oor, w_act, w_to;
  logic [CONN_W-1:0]   w_sel;
  state_e              w_cur, w_nxt;
  logic [RTY_W-1:0]    w_rty;
  logic [3:0]          w_fl, w_cm, w_txf;
  logic                w_reload, w_rty_inc;
  logic                w_syn, w_ack, w_fin, w_rst, w_aopn, w_popn, w_cls, w_send;

  // A timer expires in the cycle it holds 1; that cycle may already service it.
  for (genvar g = 0; g < NUM_CONN; g++) begin : g_conn
    assign w_exp[g] = r_armed[g] && (r_tmr[g] == TMR_W'(1));
    assign bus.state_o[4*g +: 4] = r_state[g];
  end
  assign w_due = r_pend | w_exp;

  always_comb begin
    w_oor = bus.evt_valid && ({1'b0, bus.evt_conn} >= (CONN_W+1)'(NUM_CONN));
    w_act = 1'b0;
    w_to  = 1'b0;
    w_sel = '0;
    if (bus.evt_valid) begin
      if (!w_oor) begin
        w_act = 1'b1;
        w_sel = bus.evt_conn;
      end
    end else begin
      for (int i = NUM_CONN - 1; i >= 0; i--) begin
        if (w_due[i]) begin
          w_act = 1'b1;
          w_to  = 1'b1;
          w_sel = CONN_W'(i);
        end
      end
    end
  end

  assign w_cur = r_state[w_sel];
  assign w_rty = r_retry[w_sel];
  assign w_fl  = w_to ? 4'b0 : bus.evt_flags;
  assign w_cm  = w_to ? 4'b0 : bus.evt_cmd;
  assign {w_syn, w_ack, w_fin, w_rst}    = w_fl;
  assign {w_aopn, w_popn, w_cls, w_send} = w_cm;

  always_comb begin
    w_nxt     = w_cur;
    w_txf     = '0;
    w_reload  = 1'b0;
    w_rty_inc = 1'b0;
    case (w_cur)
      S_CLOSED:
        if (w_aopn)      begin w_nxt = S_SYN_SENT; w_txf = F_SYN; end
        else if (w_popn) w_nxt = S_LISTEN;
      S_LISTEN:
        if (w_cls)       w_nxt = S_CLOSED;
        else if (w_send) begin w_nxt = S_SYN_SENT; w_txf = F_SYN; end
        else if (w_syn)  begin w_nxt = S_SYN_RCVD; w_txf = F_SYN | F_ACK; end
      S_SYN_SENT:
        if (w_cls) w_nxt = S_CLOSED;
        else if (w_to && (w_rty < RTY_W'(MAX_RETRY))) begin
          w_txf = F_SYN; w_reload = 1'b1; w_rty_inc = 1'b1;
        end
        else if (w_to)             begin w_nxt = S_CLOSED; w_txf = F_RST; end
        else if (w_syn && w_ack)   begin w_nxt = S_ESTAB; w_txf = F_ACK; end
        else if (w_syn)            begin w_nxt = S_SYN_RCVD; w_txf = F_SYN | F_ACK; end
      S_SYN_RCVD:
        if (w_cls)      begin w_nxt = S_FIN_WAIT_1; w_txf = F_FIN; end
        else if (w_to)  begin w_nxt = S_CLOSED; w_txf = F_RST; end
        else if (w_ack) w_nxt = S_ESTAB;
        else if (w_rst) w_nxt = S_LISTEN;
      S_ESTAB:
        if (w_cls)      begin w_nxt = S_FIN_WAIT_1; w_txf = F_FIN; end
        else if (w_fin) begin w_nxt = S_CLOSE_WAIT; w_txf = F_ACK; end
        else if (w_rst) w_nxt = S_LISTEN;
      S_FIN_WAIT_1:
        if (w_fin && w_ack) begin w_nxt = S_TIME_WAIT; w_txf = F_ACK; end
        else if (w_fin)     begin w_nxt = S_CLOSING; w_txf = F_ACK; end
        else if (w_ack)     w_nxt = S_FIN_WAIT_2;
      S_FIN_WAIT_2:
        if (w_fin) begin w_nxt = S_TIME_WAIT; w_txf = F_ACK; end
      S_CLOSE_WAIT:
        if (w_cls) begin w_nxt = S_LAST_ACK; w_txf = F_FIN; end
      S_CLOSING:
        if (w_ack) w_nxt = S_TIME_WAIT;
      S_LAST_ACK:
        if (w_ack || w_to) w_nxt = S_CLOSED;
      S_TIME_WAIT:
        if (w_to) w_nxt = S_CLOSED;
      default: w_nxt = S_CLOSED;
    endcase
  end

  // Leaving a state (or reloading) drops any pending timeout; staying keeps it.
  always_comb begin
    for (int i = 0; i < NUM_CONN; i++) begin
      w_nstate[i] = r_state[i];
      w_ntmr[i]   = r_tmr[i];
      w_nretry[i] = r_retry[i];
      w_narmed[i] = r_armed[i];
      w_npend[i]  = r_pend[i];
      if (r_armed[i]) begin
        w_ntmr[i] = r_tmr[i] - 1'b1;
        if (w_exp[i]) begin
          w_narmed[i] = 1'b0;
          w_npend[i]  = 1'b1;
        end
      end
      if (w_act && (w_sel == CONN_W'(i))) begin
        w_nstate[i] = w_nxt;
        if ((w_nxt != w_cur) || w_reload) begin
          w_npend[i] = 1'b0;
          case (w_nxt)
            S_SYN_SENT, S_SYN_RCVD, S_LAST_ACK: begin
              w_ntmr[i] = TMR_W'(TIMEOUT_CYCLES); w_narmed[i] = 1'b1;
            end
            S_TIME_WAIT: begin
              w_ntmr[i] = TMR_W'(TW_CYCLES); w_narmed[i] = 1'b1;
            end
            default: begin
              w_ntmr[i] = '0; w_narmed[i] = 1'b0;
            end
          endcase
        end
        if (w_to) w_npend[i] = 1'b0;
        if ((w_nxt == S_SYN_SENT) && ((w_cur == S_CLOSED) || (w_cur == S_LISTEN)))
          w_nretry[i] = '0;
        else if (w_rty_inc)
          w_nretry[i] = w_rty + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CONN; i++) begin
        r_state[i] <= S_CLOSED;
        r_tmr[i]   <= '0;
        r_retry[i] <= '0;
      end
      r_armed    <= '0;
      r_pend     <= '0;
      r_tx_valid <= 1'b0;
      r_tx_conn  <= '0;
      r_tx_flags <= '0;
      r_err      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CONN; i++) begin
        r_state[i] <= w_nstate[i];
        r_tmr[i]   <= w_ntmr[i];
        r_retry[i] <= w_nretry[i];
      end
      r_armed    <= w_narmed;
      r_pend     <= w_npend;
      r_tx_valid <= w_act && (w_txf != 4'b0);
      r_tx_conn  <= (w_act && (w_txf != 4'b0)) ? w_sel : '0;
      r_tx_flags <= w_act ? w_txf : 4'b0;
      r_err      <= w_oor;
    end
  end

  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_conn  = r_tx_conn;
  assign bus.tx_flags = r_tx_flags;
  assign bus.err_o    = r_err;
endmodule

// File: tb/tb_tcp_conn_fsm_multi.sv
// Bench for tcp_conn_fsm_multi: directed table, timing sequences and random
// traffic checked against a deadline-based reference model.
module tb_tcp_conn_fsm_multi;
  localparam int N  = 5;
  localparam int CW = 3;
  localparam int TO = 16;
  localparam int TW = 32;
  localparam int MR = 2;
  localparam logic [3:0] SYN = 4'b1000, ACK = 4'b0100, FIN = 4'b0010, RST = 4'b0001;
  localparam logic [3:0] AOPN = 4'b1000, POPN = 4'b0100, CLS = 4'b0010, SEND = 4'b0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  tcp_conn_fsm_multi_if #(.NUM_CONN(N), .CONN_W(CW)) bus ();
  tcp_conn_fsm_multi #(.NUM_CONN(N), .CONN_W(CW), .TIMEOUT_CYCLES(TO), .TW_CYCLES(TW),
                       .TMR_W(16), .MAX_RETRY(MR))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;  // index of the next rising edge

  // Model: per-connection state, absolute timeout deadline, retry count.
  int   m_st [N];
  bit   m_arm[N];
  int   m_dl [N];
  int   m_rty[N];
  bit   e_txv;
  int   e_txc;
  logic [3:0] e_txf;
  bit   e_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, t - 1, act, exp);
    end
  endtask

  function automatic int st_of(input int c);
    return int'(bus.state_o[4*c +: 4]);
  endfunction

  function automatic bit timed(input int s);
    return (s == 2) || (s == 3) || (s == 9) || (s == 10);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_arm[i] = 0; m_dl[i] = 0; m_rty[i] = 0;
    end
  endtask

  task automatic m_apply(input int c, input bit to, input logic [3:0] f, input logic [3:0] m);
    int s, ns;
    logic [3:0] tx;
    bit again, syn, ack, fin, rst, ao, po, cl, sd;
    s = m_st[c]; ns = s; tx = 4'b0; again = 0;
    {syn, ack, fin, rst} = f;
    {ao, po, cl, sd} = m;
    case (s)
      0: if (ao) begin ns = 2; tx = SYN; end else if (po) ns = 1;
      1: if (cl) ns = 0; else if (sd) begin ns = 2; tx = SYN; end
         else if (syn) begin ns = 3; tx = SYN | ACK; end
      2: if (cl) ns = 0;
         else if (to && m_rty[c] < MR) begin tx = SYN; m_rty[c]++; again = 1; end
         else if (to) begin ns = 0; tx = RST; end
         else if (syn && ack) begin ns = 4; tx = ACK; end
         else if (syn) begin ns = 3; tx = SYN | ACK; end
      3: if (cl) begin ns = 5; tx = FIN; end else if (to) begin ns = 0; tx = RST; end
         else if (ack) ns = 4; else if (rst) ns = 1;
      4: if (cl) begin ns = 5; tx = FIN; end else if (fin) begin ns = 7; tx = ACK; end
         else if (rst) ns = 1;
      5: if (fin && ack) begin ns = 10; tx = ACK; end else if (fin) begin ns = 8; tx = ACK; end
         else if (ack) ns = 6;
      6: if (fin) begin ns = 10; tx = ACK; end
      7: if (cl) begin ns = 9; tx = FIN; end
      8: if (ack) ns = 10;
      9: if (ack || to) ns = 0;
      10: if (to) ns = 0;
      default: ns = 0;
    endcase
    if (ns == 2 && (s == 0 || s == 1)) m_rty[c] = 0;
    if (ns != s || again) begin
      m_arm[c] = timed(ns);
      m_dl[c]  = t + ((ns == 10) ? TW : TO);
    end
    m_st[c] = ns;
    if (tx != 4'b0) begin e_txv = 1; e_txc = c; e_txf = tx; end
  endtask

  // Predict the edge from the inputs now on the bus, take the edge, compare.
  task automatic tick();
    logic [4*N-1:0] ms;
    e_txv = 0; e_txc = 0; e_txf = 4'b0; e_err = 0;
    if (bus.evt_valid) begin
      if (int'(bus.evt_conn) >= N) e_err = 1;
      else m_apply(int'(bus.evt_conn), 0, bus.evt_flags, bus.evt_cmd);
    end else begin
      for (int i = 0; i < N; i++)
        if (m_arm[i] && m_dl[i] <= t) begin m_apply(i, 1, 4'b0, 4'b0); break; end
    end
    @(posedge clk); #1; t++;
    for (int i = 0; i < N; i++) ms[4*i +: 4] = 4'(m_st[i]);
    chk("model state_o", 64'(bus.state_o), 64'(ms));
    chk("model tx_valid", 64'(bus.tx_valid), 64'(e_txv));
    chk("model err_o", 64'(bus.err_o), 64'(e_err));
    if (e_txv) begin
      chk("model tx_conn", 64'(bus.tx_conn), 64'(e_txc));
      chk("model tx_flags", 64'(bus.tx_flags), 64'(e_txf));
    end
  endtask

  task automatic ev(input int c, input logic [3:0] f, input logic [3:0] m);
    bus.evt_valid = 1'b1; bus.evt_conn = CW'(c); bus.evt_flags = f; bus.evt_cmd = m;
    tick();
  endtask

  task automatic idle();
    bus.evt_valid = 1'b0; bus.evt_conn = '0; bus.evt_flags = '0; bus.evt_cmd = '0;
    tick();
  endtask

  task automatic hold_reset();
    m_reset();
    repeat (2) begin @(posedge clk); t++; end
    @(negedge clk); rst_n = 1'b1;
  endtask

  typedef struct {
    bit         v;
    int         c;
    logic [3:0] f;
    logic [3:0] m;
    bit         txv;
    logic [3:0] txf;
    int         sc;
    int         st;
    bit         err;
  } vec_t;
  vec_t vec[14];

  int t_la, t_tw, cl2, cl3, txv2, st1_at3, e0, a, n;
  int tx_edge[3];
  logic [3:0] tx_fl[3];

  initial begin
    vec[0]  = '{1, 1, 4'b0,      AOPN, 1, SYN,       1, 2,  0};
    vec[1]  = '{1, 1, SYN | ACK, 4'b0, 1, ACK,       1, 4,  0};
    vec[2]  = '{1, 2, 4'b0,      POPN, 0, 4'b0,      2, 1,  0};
    vec[3]  = '{1, 2, SYN,       4'b0, 1, SYN | ACK, 2, 3,  0};
    vec[4]  = '{1, 2, ACK,       4'b0, 0, 4'b0,      2, 4,  0};
    vec[5]  = '{1, 2, FIN,       4'b0, 1, ACK,       2, 7,  0};
    vec[6]  = '{1, 2, 4'b0,      CLS,  1, FIN,       2, 9,  0};
    vec[7]  = '{1, 3, 4'b0,      AOPN, 1, SYN,       3, 2,  0};
    vec[8]  = '{1, 3, SYN | ACK, 4'b0, 1, ACK,       3, 4,  0};
    vec[9]  = '{1, 3, 4'b0,      CLS,  1, FIN,       3, 5,  0};
    vec[10] = '{1, 3, FIN,       4'b0, 1, ACK,       3, 8,  0};
    vec[11] = '{1, 3, ACK,       4'b0, 0, 4'b0,      3, 10, 0};
    vec[12] = '{1, N, SYN,       AOPN, 0, 4'b0,      3, 10, 1};
    vec[13] = '{1, 1, 4'b0,      CLS,  1, FIN,       1, 5,  0};

    bus.evt_valid = 1'b0; bus.evt_conn = '0; bus.evt_flags = '0; bus.evt_cmd = '0;
    hold_reset();
    #1;
    chk("reset state_o", 64'(bus.state_o), 64'd0);
    chk("reset tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("reset tx_flags", 64'(bus.tx_flags), 64'd0);
    chk("reset tx_conn", 64'(bus.tx_conn), 64'd0);
    chk("reset err_o", 64'(bus.err_o), 64'd0);
    @(negedge clk);

    // Directed table: active open, passive open/close, simultaneous close, bad id.
    t_la = 0; t_tw = 0;
    for (int k = 0; k < 14; k++) begin
      if (vec[k].v) ev(vec[k].c, vec[k].f, vec[k].m); else idle();
      chk($sformatf("vec%0d tx_valid", k), 64'(bus.tx_valid), 64'(vec[k].txv));
      chk($sformatf("vec%0d err_o", k), 64'(bus.err_o), 64'(vec[k].err));
      chk($sformatf("vec%0d state", k), 64'(st_of(vec[k].sc)), 64'(vec[k].st));
      if (vec[k].txv) begin
        chk($sformatf("vec%0d tx_conn", k), 64'(bus.tx_conn), 64'(vec[k].c));
        chk($sformatf("vec%0d tx_flags", k), 64'(bus.tx_flags), 64'(vec[k].txf));
      end
      if (k == 6)  t_la = t - 1;
      if (k == 11) t_tw = t - 1;
    end

    // LAST_ACK times out silently; TIME_WAIT closes exactly TW edges after entry.
    cl2 = -1; cl3 = -1; txv2 = 1; st1_at3 = -1;
    for (int k = 0; k < 60 && (cl2 < 0 || cl3 < 0); k++) begin
      idle();
      if (cl2 < 0 && st_of(2) == 0) begin cl2 = t - 1; txv2 = int'(bus.tx_valid); end
      if (cl3 < 0 && st_of(3) == 0) begin cl3 = t - 1; st1_at3 = st_of(1); end
    end
    chk("last_ack timeout edge", 64'(cl2 - t_la), 64'(TO));
    chk("last_ack timeout no tx", 64'(txv2), 64'd0);
    chk("time_wait close edge", 64'(cl3 - t_tw), 64'(TW));
    chk("time_wait other conn", 64'(st1_at3), 64'd5);

    // SYN retry exhaustion on conn0, then retry count restarts on reopen.
    ev(0, 4'b0, AOPN);
    e0 = t - 1; n = 0;
    for (int k = 0; k < 70 && n < 3; k++) begin
      idle();
      if (bus.tx_valid && bus.tx_conn == 0) begin
        tx_edge[n] = t - 1; tx_fl[n] = bus.tx_flags; n++;
      end
    end
    chk("retry tx count", 64'(n), 64'd3);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("retry%0d edge", j), 64'(tx_edge[j] - e0), 64'(TO * (j + 1)));
      chk($sformatf("retry%0d flags", j), 64'(tx_fl[j]), 64'((j < 2) ? SYN : RST));
    end
    chk("retry give-up state", 64'(st_of(0)), 64'd0);
    ev(0, 4'b0, AOPN);
    e0 = t - 1; n = 0;
    for (int k = 0; k < 20 && n < 1; k++) begin
      idle();
      if (bus.tx_valid && bus.tx_conn == 0) begin tx_edge[0] = t - 1; tx_fl[0] = bus.tx_flags; n++; end
    end
    chk("reopen first timeout seen", 64'(n), 64'd1);
    chk("reopen retry cleared", 64'(tx_fl[0]), 64'(SYN));
    chk("reopen timeout edge", 64'(tx_edge[0] - e0), 64'(TO));
    ev(0, 4'b0, CLS);

    // Two timers expire in the same cycle an event hits one of them.
    ev(1, FIN | ACK, 4'b0);
    a = t - 1;
    chk("collide conn1 time_wait", 64'(st_of(1)), 64'd10);
    while (t < a + 15) idle();
    ev(0, 4'b0, POPN);
    ev(0, SYN, 4'b0);
    while (t < a + 32) idle();
    ev(0, ACK, 4'b0);
    chk("collide conn0 estab", 64'(st_of(0)), 64'd4);
    chk("collide conn1 held", 64'(st_of(1)), 64'd10);
    idle();
    chk("collide conn1 TO next idle", 64'(st_of(1)), 64'd0);
    chk("collide no tx", 64'(bus.tx_valid), 64'd0);
    repeat (20) idle();
    chk("collide conn0 pend dropped", 64'(st_of(0)), 64'd4);

    // Asynchronous reset in the middle of a handshake.
    ev(2, 4'b0, AOPN);
    #3 rst_n = 1'b0;
    #1;
    chk("async reset state_o", 64'(bus.state_o), 64'd0);
    chk("async reset tx_valid", 64'(bus.tx_valid), 64'd0);
    hold_reset();

    // Random traffic, including out-of-range ids and idle gaps for timeouts.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 9) < 5)
        ev($urandom_range(0, N), 4'($urandom_range(0, 15)), 4'(5'd1 << $urandom_range(0, 4)));
      else
        idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
